// File: rtl/perf_counter_reader_pkg.sv
// Shared constants for the performance-counter read side:
// address map, dump framing and FSM state encodings.
package perf_counter_reader_pkg;

    localparam int          NUM_CTRS   = 5;
    localparam int          HI_W       = 32;
    localparam int          LO_W       = 32;
    localparam logic [31:0] DUMP_MAGIC = 32'hC0FFEE01;

    localparam logic [3:0] ADDR_LO_BASE = 4'd0;
    localparam logic [3:0] ADDR_HI_BASE = 4'd5;
    localparam logic [3:0] ADDR_SNAP_ID = 4'd10;
    localparam logic [3:0] ADDR_STATUS  = 4'd11;

    localparam logic [3:0] DUMP_LAST_IDX = 4'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;

endpackage

// File: rtl/perf_counter_reader_if.sv
// Read request / response channel between a debug master
// and the performance-counter reader.
interface perf_counter_reader_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_last;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err, resp_last
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err, resp_last
    );

endinterface

// File: rtl/perf_counter_reader_counter_wrap_ext.sv
// Extends one free-running counter with a wrap-count high word.
// ext is combinational so a wrap in the current cycle is visible.
module counter_wrap_ext #(
    parameter int LO_W = 32,
    parameter int HI_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LO_W-1:0]      cur,
    output logic [LO_W+HI_W-1:0] ext
);

    logic [LO_W-1:0] prev;
    logic [HI_W-1:0] hi;
    logic [HI_W-1:0] hi_next;
    logic            wrap;

    assign wrap    = (cur < prev);
    assign hi_next = hi + {{(HI_W-1){1'b0}}, wrap};
    assign ext     = {hi_next, cur};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
            hi   <= '0;
        end else begin
            prev <= cur;
            hi   <= hi_next;
        end
    end

endmodule

// File: rtl/perf_counter_reader.sv
// Samples the core perf counters, keeps 64-bit shadows and serves
// single-word reads or a framed 11-word dump over a valid/ready channel.
module perf_counter_reader
    import perf_counter_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           cycle_count_i,
    input  logic [31:0]           instruction_count_i,
    input  logic [31:0]           stall_count_i,
    input  logic [31:0]           branch_count_i,
    input  logic [31:0]           branch_mispredicts_i,
    perf_counter_reader_if.slave  bus,
    input  logic                  dump_start,
    output logic                  dump_busy,
    output logic [7:0]            snapshot_id
);

    logic [LO_W-1:0]      cur [NUM_CTRS];
    logic [LO_W+HI_W-1:0] ext [NUM_CTRS];

    assign cur[0] = cycle_count_i;
    assign cur[1] = instruction_count_i;
    assign cur[2] = stall_count_i;
    assign cur[3] = branch_count_i;
    assign cur[4] = branch_mispredicts_i;

    for (genvar k = 0; k < NUM_CTRS; k++) begin : g_ext
        counter_wrap_ext #(.LO_W(LO_W), .HI_W(HI_W)) u_ext (
            .clk   (clk),
            .reset (reset),
            .cur   (cur[k]),
            .ext   (ext[k])
        );
    end

    // Shadow words 0..4 hold lo halves, 5..9 hi halves, matching the map.
    logic [31:0] shadow_w [2*NUM_CTRS];
    logic [1:0]  state;
    logic [3:0]  idx;
    logic [31:0] data_q;
    logic        err_q;

    logic        in_idle;
    logic        start_dump;
    logic        accept;
    logic        snap;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [3:0]  half;
    logic [3:0]  dump_sel;
    logic [31:0] dump_word;

    assign in_idle    = (state == ST_IDLE);
    assign start_dump = in_idle && dump_start;
    assign accept     = in_idle && !dump_start && bus.req_valid;
    assign snap       = start_dump
                      || (accept && bus.req_addr == ADDR_LO_BASE);

    assign bus.req_ready = in_idle && !dump_start;
    assign dump_busy     = (state == ST_DUMP);

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (bus.req_addr == ADDR_LO_BASE) begin
            rd_data = ext[0][31:0];
        end else if (bus.req_addr < ADDR_SNAP_ID) begin
            rd_data = shadow_w[bus.req_addr];
        end else if (bus.req_addr == ADDR_SNAP_ID) begin
            rd_data = {24'b0, snapshot_id};
        end else if (bus.req_addr == ADDR_STATUS) begin
            rd_data = {31'b0, dump_busy};
        end else begin
            rd_err = 1'b1;
        end
    end

    // Dump order after the magic word: lo0,hi0,lo1,hi1,...
    assign half     = (idx - 4'd1) >> 1;
    assign dump_sel = idx[0] ? half : half + ADDR_HI_BASE;

    always_comb begin
        dump_word = DUMP_MAGIC;
        if (idx != 4'd0) begin
            dump_word = shadow_w[dump_sel];
        end
    end

    always_comb begin
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.resp_err   = 1'b0;
        bus.resp_last  = 1'b0;
        unique case (1'b1)
            (state == ST_RESP): begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = data_q;
                bus.resp_err   = err_q;
                bus.resp_last  = 1'b1;
            end
            (state == ST_DUMP): begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = dump_word;
                bus.resp_last  = (idx == DUMP_LAST_IDX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (start_dump) begin
                        state <= ST_DUMP;
                        idx   <= '0;
                    end else if (accept) begin
                        state  <= ST_RESP;
                        data_q <= rd_data;
                        err_q  <= rd_err;
                    end
                end
                (state == ST_RESP): begin
                    if (bus.resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                (state == ST_DUMP): begin
                    if (bus.resp_ready) begin
                        if (idx == DUMP_LAST_IDX) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot_id <= '0;
            for (int k = 0; k < 2*NUM_CTRS; k++) begin
                shadow_w[k] <= '0;
            end
        end else if (snap) begin
            snapshot_id <= snapshot_id + 8'd1;
            for (int k = 0; k < NUM_CTRS; k++) begin
                shadow_w[k]          <= ext[k][31:0];
                shadow_w[k+NUM_CTRS] <= ext[k][63:32];
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Scoreboard bench for perf_counter_reader: directed reads,
// wrap cases, framed dumps under backpressure and mid-dump reset.
module tb_perf_counter_reader;
    import perf_counter_reader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cyc, ins, stl, brn, mis;
    logic        dump_start;
    logic        dump_busy;
    logic [7:0]  snapshot_id;

    perf_counter_reader_if bus();

    perf_counter_reader dut (
        .clk                  (clk),
        .reset                (reset),
        .cycle_count_i        (cyc),
        .instruction_count_i  (ins),
        .stall_count_i        (stl),
        .branch_count_i       (brn),
        .branch_mispredicts_i (mis),
        .bus                  (bus),
        .dump_start           (dump_start),
        .dump_busy            (dump_busy),
        .snapshot_id          (snapshot_id)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    logic [33:0] exp_q[$];
    bit          rand_ready = 1'b0;
    logic [31:0] exp_lo [5];
    logic [31:0] exp_hi [5];
    logic        held = 1'b0;
    logic [31:0] held_data;
    logic [33:0] mon_e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    initial begin
        bus.resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset || !bus.resp_valid) begin
            held = 1'b0;
        end else begin
            if (held) check("hold_stable", bus.resp_data, held_data);
            if (bus.resp_ready) begin
                held = 1'b0;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %h expected none",
                             bus.resp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_data", bus.resp_data, mon_e[31:0]);
                    check("resp_err", {31'b0, bus.resp_err},
                          {31'b0, mon_e[32]});
                    check("resp_last", {31'b0, bus.resp_last},
                          {31'b0, mon_e[33]});
                end
            end else begin
                held      = 1'b1;
                held_data = bus.resp_data;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        check({tag, "_resp_data"}, bus.resp_data, 32'd0);
        check({tag, "_resp_err"}, {31'b0, bus.resp_err}, 32'd0);
        check({tag, "_resp_last"}, {31'b0, bus.resp_last}, 32'd0);
        check({tag, "_dump_busy"}, {31'b0, dump_busy}, 32'd0);
        check({tag, "_snap_id"}, {24'b0, snapshot_id}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        dump_start = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!bus.resp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [3:0] addr, input logic [31:0] d,
                          input logic err);
        bit acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = 1'b1;
                exp_q.push_back({1'b1, err, d});
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!acc) begin
            fail_now("req_accept");
        end else begin
            @(negedge clk);
            check("resp_latency", {31'b0, bus.resp_valid}, 32'd1);
            wait_idle();
        end
    endtask

    task automatic push_dump();
        exp_q.push_back({1'b0, 1'b0, DUMP_MAGIC});
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({1'b0, 1'b0, exp_lo[k]});
            exp_q.push_back({k == 4, 1'b0, exp_hi[k]});
        end
    endtask

    task automatic wait_dump_done();
        bit done = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (!dump_busy) begin
                done = 1'b1;
                break;
            end
            check("dump_req_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        if (!done) fail_now("dump_done");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) fail_now("drain");
    endtask

    initial begin
        cyc = '0; ins = '0; stl = '0; brn = '0; mis = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        dump_start    = 1'b0;
        #1;
        do_reset();

        // Basic reads
        cyc = 32'd100; ins = 32'd50; stl = 32'd7; brn = 32'd20; mis = 32'd3;
        tick();
        do_req(4'd0, 32'd100, 1'b0);
        check("snap_id_t1", {24'b0, snapshot_id}, 32'd1);
        do_req(4'd1, 32'd50, 1'b0);
        do_req(4'd2, 32'd7, 1'b0);
        do_req(4'd3, 32'd20, 1'b0);
        do_req(4'd4, 32'd3, 1'b0);
        do_req(4'd5, 32'd0, 1'b0);
        do_req(4'd9, 32'd0, 1'b0);
        do_req(4'd10, 32'd1, 1'b0);
        do_req(4'd11, 32'd0, 1'b0);
        do_req(4'd12, 32'd0, 1'b1);
        do_req(4'd15, 32'd0, 1'b1);

        // Wrap extension
        cyc = 32'hFFFF_FFFE; tick();
        cyc = 32'hFFFF_FFFF; tick();
        cyc = 32'h0000_0002; tick();
        do_req(4'd0, 32'd2, 1'b0);
        do_req(4'd5, 32'd1, 1'b0);
        cyc = 32'hFFFF_FFFF; tick();
        cyc = 32'h0000_0001; tick();
        do_req(4'd5, 32'd1, 1'b0);
        do_req(4'd0, 32'd1, 1'b0);
        do_req(4'd5, 32'd2, 1'b0);
        do_req(4'd10, 32'd3, 1'b0);

        // Snapshot in the same cycle as a wrap
        cyc = 32'hFFFF_FFFF;
        do_reset();
        tick(2);
        cyc = 32'h0;
        do_req(4'd0, 32'd0, 1'b0);
        do_req(4'd5, 32'd1, 1'b0);
        tick(3);
        do_req(4'd0, 32'd0, 1'b0);
        do_req(4'd5, 32'd1, 1'b0);
        check("snap_id_t3", {24'b0, snapshot_id}, 32'd2);

        // Dump with random backpressure
        cyc = 32'h1000; ins = 32'h200; stl = 32'h30; brn = 32'h40; mis = 32'h5;
        tick();
        exp_lo = '{32'h1000, 32'h200, 32'h30, 32'h40, 32'h5};
        exp_hi = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        rand_ready = 1'b1;
        push_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_dump_done();
        wait_drain();
        check("snap_id_t4", {24'b0, snapshot_id}, 32'd3);

        // dump_start beats a same-cycle request
        push_dump();
        dump_start = 1'b1;
        fork
            begin
                tick();
                dump_start = 1'b0;
            end
            do_req(4'd10, 32'd4, 1'b0);
        join
        wait_drain();
        check("snap_id_t5", {24'b0, snapshot_id}, 32'd4);

        // Unmapped read, then reset in the middle of a dump
        do_req(4'd13, 32'd0, 1'b1);
        push_dump();
        begin
            int base;
            base = hs_cnt;
            dump_start = 1'b1;
            tick();
            dump_start = 1'b0;
            for (int n = 0; n < 500 && hs_cnt < base + 3; n++) begin
                @(negedge clk);
            end
            if (hs_cnt < base + 3) fail_now("dump_word4");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("post_reset_valid", {31'b0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        do_req(4'd10, 32'd0, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
